// File: rtl/main_net_argument_max_seq.sv
// Output-layer arg-max: collects NUMBER_OF_OUTPUT_NODE floats by address, then
// scans them one per cycle with a sign-magnitude key compare and strobes the winner.
module main_net_argument_max_seq #(
   parameter int DATA_WIDTH            = 32,
   parameter int EXP_WIDTH             = 8,
   parameter int NUMBER_OF_OUTPUT_NODE = 3,
   parameter int ACTION_WIDTH          = (NUMBER_OF_OUTPUT_NODE > 2) ? $clog2(NUMBER_OF_OUTPUT_NODE) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_clear,
   input  logic                    i_data_valid,
   input  logic [ACTION_WIDTH-1:0] i_data_addr,
   input  logic [DATA_WIDTH-1:0]   i_data,
   output logic                    o_ready,
   output logic [ACTION_WIDTH-1:0] o_arg_max,
   output logic [DATA_WIDTH-1:0]   o_max_value,
   output logic                    o_arg_max_valid
);

   localparam int N          = NUMBER_OF_OUTPUT_NODE;
   localparam int MANT_WIDTH = DATA_WIDTH - 1 - EXP_WIDTH;
   localparam logic [DATA_WIDTH-1:0] SIGN_BIT = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   typedef enum logic {ST_COLLECT, ST_SCAN} state_t;

   state_t                  r_state, w_state_next;
   logic [DATA_WIDTH-1:0]   r_buf [N];
   logic [N-1:0]            r_fill;
   logic [N-1:0]            w_fill_set;
   logic [ACTION_WIDTH-1:0] r_scan_idx;
   logic [ACTION_WIDTH-1:0] r_run_idx;
   logic [DATA_WIDTH-1:0]   r_run_max;
   logic                    w_in_range;
   logic                    w_wr_en;
   logic                    w_fill_full;
   logic                    w_last_idx;
   logic                    w_take;
   logic [DATA_WIDTH-1:0]   w_cand;
   logic [DATA_WIDTH-1:0]   w_best_val;
   logic [ACTION_WIDTH-1:0] w_best_idx;

   function automatic logic f_is_nan(input logic [DATA_WIDTH-1:0] v);
      return (&v[DATA_WIDTH-2 -: EXP_WIDTH]) && (|v[MANT_WIDTH-1:0]);
   endfunction

   // Maps a float onto an unsigned key whose order matches numeric order; -0 folds to +0.
   function automatic logic [DATA_WIDTH-1:0] f_key(input logic [DATA_WIDTH-1:0] v);
      logic [DATA_WIDTH-1:0] n;
      n = (v == SIGN_BIT) ? '0 : v;
      return n[DATA_WIDTH-1] ? ~n : (n | SIGN_BIT);
   endfunction

   assign w_in_range  = {1'b0, i_data_addr} < (ACTION_WIDTH+1)'(N);
   assign w_wr_en     = (r_state == ST_COLLECT) && i_data_valid && !i_clear && w_in_range;
   assign w_fill_full = &(r_fill | w_fill_set);
   assign w_last_idx  = (r_scan_idx == ACTION_WIDTH'(N-1));
   assign w_cand      = r_buf[r_scan_idx];

   // NOTE: every variable assigned in a combinational block gets a default first,
   // otherwise a path that skips the assignment infers a latch.
   always_comb begin
      w_fill_set = '0;
      if (w_wr_en) w_fill_set[i_data_addr] = 1'b1;
   end

   // Entry 0 seeds the running max; later entries win only when strictly greater,
   // and a NaN never displaces anything.
   always_comb begin
      w_take = (r_scan_idx == '0) ||
               (!f_is_nan(w_cand) && (f_is_nan(r_run_max) || (f_key(w_cand) > f_key(r_run_max))));
      w_best_val = w_take ? w_cand     : r_run_max;
      w_best_idx = w_take ? r_scan_idx : r_run_idx;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_COLLECT;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_COLLECT: if (w_wr_en && w_fill_full) w_state_next = ST_SCAN;
         ST_SCAN:    if (w_last_idx)             w_state_next = ST_COLLECT;
         default:                                w_state_next = ST_COLLECT;
      endcase
   end

   always_comb begin
      o_ready = (r_state == ST_COLLECT);
   end

   // NOTE: the value buffer has no reset; its contents are only read after every
   // slot has been written, so a reset would cost routing for no benefit.
   always_ff @(posedge clk) begin
      if (w_wr_en) r_buf[i_data_addr] <= i_data;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fill          <= '0;
         r_scan_idx      <= '0;
         r_run_idx       <= '0;
         r_run_max       <= '0;
         o_arg_max       <= '0;
         o_max_value     <= '0;
         o_arg_max_valid <= 1'b0;
      end else begin
         o_arg_max_valid <= 1'b0;
         if (r_state == ST_COLLECT) begin
            r_scan_idx <= '0;
            if (i_clear) r_fill <= '0;
            else         r_fill <= r_fill | w_fill_set;
         end else begin
            r_run_max  <= w_best_val;
            r_run_idx  <= w_best_idx;
            r_scan_idx <= r_scan_idx + ACTION_WIDTH'(1);
            if (w_last_idx) begin
               o_arg_max       <= w_best_idx;
               o_max_value     <= w_best_val;
               o_arg_max_valid <= 1'b1;
               r_fill          <= '0;
               r_scan_idx      <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_main_net_argument_max_seq.sv
// Bench for main_net_argument_max_seq: directed and random vectors on N=3 and N=8
// instances, checked against a numeric sign-magnitude reference model.
module tb_main_net_argument_max_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst3, clr3, v3, rdy3, val3;
   logic [1:0]  a3, arg3;
   logic [31:0] d3, max3;
   logic        rst8, clr8, v8, rdy8, val8;
   logic [2:0]  a8, arg8;
   logic [31:0] d8, max8;

   main_net_argument_max_seq #(.NUMBER_OF_OUTPUT_NODE(3)) u_dut3 (
      .clk(clk), .rst(rst3), .i_clear(clr3), .i_data_valid(v3), .i_data_addr(a3),
      .i_data(d3), .o_ready(rdy3), .o_arg_max(arg3), .o_max_value(max3), .o_arg_max_valid(val3));

   main_net_argument_max_seq #(.NUMBER_OF_OUTPUT_NODE(8)) u_dut8 (
      .clk(clk), .rst(rst8), .i_clear(clr8), .i_data_valid(v8), .i_data_addr(a8),
      .i_data(d8), .o_ready(rdy8), .o_arg_max(arg8), .o_max_value(max8), .o_arg_max_valid(val8));

   int          checks = 0;
   int          errors = 0;
   int          sel    = 3;
   logic [31:0] mdl [8];
   logic        m_rdy, m_val;
   int          m_arg;
   logic [31:0] m_max;

   always_comb begin
      if (sel == 8) begin
         m_rdy = rdy8; m_val = val8; m_arg = int'(arg8); m_max = max8;
      end else begin
         m_rdy = rdy3; m_val = val3; m_arg = int'(arg3); m_max = max3;
      end
   end

   // Reference: a float's numeric order equals order of its signed magnitude.
   function automatic bit is_nan(input logic [31:0] v);
      return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
   endfunction

   function automatic longint sval(input logic [31:0] v);
      longint m;
      m = longint'(v[30:0]);
      return v[31] ? -m : m;
   endfunction

   function automatic int ref_idx(input int n);
      int best;
      best = -1;
      for (int k = 0; k < n; k++)
         if (!is_nan(mdl[k]) && (best < 0 || sval(mdl[k]) > sval(mdl[best]))) best = k;
      return (best < 0) ? 0 : best;
   endfunction

   function automatic logic [31:0] rval();
      case ($urandom_range(0, 7))
         0:       return 32'h7F800000 | 32'($urandom_range(1, 32'h7FFFFF));
         1:       return 32'h80000000;
         2:       return 32'h00000000;
         3:       return 32'h7F800000;
         4:       return 32'hFF800000;
         5:       return ($urandom_range(0, 1) != 0) ? 32'h3F800000 : 32'hBF800000;
         default: return 32'($urandom);
      endcase
   endfunction

   // Called at a falling edge; drives one write across the next rising edge.
   task automatic wr(input int addr, input logic [31:0] data);
      checks++;
      if (m_rdy !== 1'b1) begin
         errors++;
         $display("FAIL wr_ready addr=%0d got %b exp 1", addr, m_rdy);
      end
      if (sel == 8) begin v8 = 1'b1; a8 = 3'(addr); d8 = data; end
      else          begin v3 = 1'b1; a3 = 2'(addr); d3 = data; end
      if (addr < sel) mdl[addr] = data;
      @(negedge clk);
      v3 = 1'b0; v8 = 1'b0;
   endtask

   // Waits for the strobe after the completing write; junk drives a write that must be ignored.
   task automatic await_result(input string name, input bit junk);
      int lat, exp_idx;
      lat = 0;
      exp_idx = ref_idx(sel);
      repeat (sel + 4) begin
         if (junk && lat == 0) begin
            if (sel == 8) begin v8 = 1'b1; a8 = 3'd0; d8 = 32'h7F000000; end
            else          begin v3 = 1'b1; a3 = 2'd0; d3 = 32'h7F000000; end
         end
         @(negedge clk);
         v3 = 1'b0; v8 = 1'b0;
         lat++;
         if (m_val === 1'b1) break;
         checks++;
         if (m_rdy !== 1'b0) begin
            errors++;
            $display("FAIL %s ready_in_scan cycle=%0d got %b exp 0", name, lat, m_rdy);
         end
      end
      checks++;
      if (m_val !== 1'b1 || lat != sel) begin
         errors++;
         $display("FAIL %s latency got %0d (strobe=%b) exp %0d", name, lat, m_val, sel);
      end else begin
         checks++;
         if (m_arg != exp_idx || m_max !== mdl[exp_idx] || m_rdy !== 1'b1) begin
            errors++;
            $display("FAIL %s result got idx=%0d val=%h rdy=%b exp idx=%0d val=%h rdy=1",
                     name, m_arg, m_max, m_rdy, exp_idx, mdl[exp_idx]);
         end
      end
   endtask

   task automatic strobe_once(input string name);
      @(negedge clk);
      checks++;
      if (m_val !== 1'b0) begin
         errors++;
         $display("FAIL %s strobe_width got %b exp 0", name, m_val);
      end
   endtask

   task automatic rand_vec(input bit junk);
      int perm [8];
      int j, t;
      for (int i = 0; i < sel; i++) perm[i] = i;
      for (int i = sel - 1; i > 0; i--) begin
         j = $urandom_range(0, i); t = perm[i]; perm[i] = perm[j]; perm[j] = t;
      end
      for (int i = 0; i < sel; i++) begin
         wr(perm[i], rval());
         if (i < sel - 1 && $urandom_range(0, 3) == 0) begin
            if (sel == 3 && $urandom_range(0, 1) != 0) wr(3, rval());
            else                                       wr(perm[$urandom_range(0, i)], rval());
         end
      end
      await_result(junk ? "scan_ignore" : "random", junk);
      strobe_once("random");
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if (rdy3 !== 1'b1 || arg3 !== 2'd0 || max3 !== 32'd0 || val3 !== 1'b0) begin
         errors++;
         $display("FAIL reset3 got rdy=%b idx=%0d val=%h stb=%b exp 1/0/0/0", rdy3, arg3, max3, val3);
      end
      checks++;
      if (rdy8 !== 1'b1 || arg8 !== 3'd0 || max8 !== 32'd0 || val8 !== 1'b0) begin
         errors++;
         $display("FAIL reset8 got rdy=%b idx=%0d val=%h stb=%b exp 1/0/0/0", rdy8, arg8, max8, val8);
      end
      rst3 = 1'b0; rst8 = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      wr(2, 32'h40400000); wr(0, 32'h3F800000); wr(1, 32'h40000000);
      await_result("basic", 1'b0);
      strobe_once("basic");
   endtask

   task automatic test_ties();
      for (int i = 0; i < 3; i++) wr(i, 32'hBF800000);
      await_result("tie_all_neg1", 1'b0);
      strobe_once("tie_all_neg1");
      wr(0, 32'h80000000); wr(1, 32'h00000000); wr(2, 32'hBF800000);
      await_result("signed_zero", 1'b0);
      strobe_once("signed_zero");
   endtask

   task automatic test_nan();
      wr(0, 32'h7FC00000); wr(1, 32'hC0000000); wr(2, 32'hBF800000);
      await_result("nan_first", 1'b0);
      strobe_once("nan_first");
      wr(1, 32'h7FC00000); wr(2, 32'hFFC00001); wr(0, 32'h7FC00000);
      await_result("all_nan", 1'b0);
      strobe_once("all_nan");
   endtask

   task automatic test_dup_oor();
      wr(0, 32'h3F800000); wr(0, 32'h40A00000); wr(3, 32'h7F7FFFFF);
      wr(1, 32'h40000000); wr(2, 32'h40400000);
      await_result("dup_oor", 1'b0);
      strobe_once("dup_oor");
   endtask

   task automatic test_clear();
      // Later writes would be refused early if the clear were ignored.
      wr(0, 32'h41000000);
      clr3 = 1'b1; wr(1, 32'h41000000); clr3 = 1'b0;
      wr(2, 32'h3F800000); wr(1, 32'hC0000000); wr(0, 32'h40000000);
      await_result("clear_a", 1'b0);
      strobe_once("clear_a");
      // And refused early here if the write beside the clear were kept.
      wr(0, 32'h41000000);
      clr3 = 1'b1; wr(1, 32'h41000000); clr3 = 1'b0;
      wr(2, 32'hC0400000); wr(0, 32'hC0000000); wr(1, 32'hBF800000);
      await_result("clear_b", 1'b0);
      strobe_once("clear_b");
   endtask

   task automatic test_back_to_back();
      wr(1, 32'h3F800000); wr(2, 32'h3F000000); wr(0, 32'hBF000000);
      await_result("b2b_first", 1'b0);
      wr(0, 32'h40000000); wr(2, 32'h40800000); wr(1, 32'h40400000);
      await_result("b2b_second", 1'b0);
      strobe_once("b2b_second");
   endtask

   task automatic test_n8();
      for (int k = 7; k >= 0; k--)
         wr(k, (k == 5) ? 32'h42C80000 : (32'h3F800000 + 32'(k << 16)));
      await_result("n8_reverse", 1'b0);
      strobe_once("n8_reverse");
   endtask

   task automatic test_rst_mid_scan();
      for (int k = 0; k < 8; k++) wr(k, 32'h40000000 + 32'(k << 12));
      repeat (3) @(negedge clk);
      rst8 = 1'b1;
      #2;
      checks++;
      if (rdy8 !== 1'b1 || arg8 !== 3'd0 || max8 !== 32'd0 || val8 !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_scan got rdy=%b idx=%0d val=%h stb=%b exp 1/0/0/0", rdy8, arg8, max8, val8);
      end
      @(negedge clk);
      rst8 = 1'b0;
      repeat (10) begin
         @(negedge clk);
         checks++;
         if (val8 !== 1'b0 || rdy8 !== 1'b1) begin
            errors++;
            $display("FAIL rst_no_strobe got stb=%b rdy=%b exp 0/1", val8, rdy8);
         end
      end
   endtask

   initial begin
      rst3 = 1'b1; rst8 = 1'b1; clr3 = 1'b0; clr8 = 1'b0;
      v3 = 1'b0; v8 = 1'b0; a3 = '0; a8 = '0; d3 = '0; d8 = '0;
      for (int i = 0; i < 8; i++) mdl[i] = '0;
      test_reset();
      sel = 3;
      test_basic();
      test_ties();
      test_nan();
      test_dup_oor();
      test_clear();
      test_back_to_back();
      rand_vec(1'b1);
      for (int i = 0; i < 40; i++) rand_vec(1'b0);
      sel = 8;
      test_n8();
      for (int i = 0; i < 10; i++) rand_vec(1'b0);
      test_n8();
      test_rst_mid_scan();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
